// File: rtl/div_unit.sv
// Multi-cycle restoring divider producing {remainder, quotient} for HI/LO writeback.
// Optional DIV_ZERO_FLAG_EN adds a registered div_zero_o flag for divide-by-zero results.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                  div_zero_o
`endif
);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W:0]   sr_q, sr_d;
  logic [DATA_W-1:0]   div_mag_q, div_mag_d;
  logic                signed_q, signed_d;
  logic                sign1_q, sign1_d;
  logic                sign2_q, sign2_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
`ifdef DIV_ZERO_FLAG_EN
  logic                dz_q, dz_d;
`endif

  logic [DATA_W-1:0]   mag1, mag2;
  logic [2*DATA_W+1:0] shifted;
  logic [DATA_W+1:0]   trial;
  logic [2*DATA_W:0]   iter_sr;
  logic [DATA_W-1:0]   quo_mag, rem_mag, quo_fin, rem_fin;

  assign mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Upper bits hold the partial remainder, lower bits the dividend turning into the quotient.
  // The bit shifted out of the top is always 0 but is kept in the trial for full width.
  assign shifted = {sr_q, 1'b0};
  assign trial   = shifted[2*DATA_W+1:DATA_W] - {2'b00, div_mag_q};
  assign iter_sr = trial[DATA_W+1] ? shifted[2*DATA_W:0]
                                   : {trial[DATA_W:0], shifted[DATA_W-1:1], 1'b1};

  assign quo_mag = iter_sr[DATA_W-1:0];
  assign rem_mag = iter_sr[2*DATA_W-1:DATA_W];
  assign quo_fin = (signed_q && (sign1_q ^ sign2_q)) ? -quo_mag : quo_mag;
  // Remainder follows the sign of the dividend.
  assign rem_fin = (signed_q && sign1_q) ? -rem_mag : rem_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    div_mag_d = div_mag_q;
    signed_d  = signed_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    result_d  = result_q;
    ready_d   = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    dz_d      = dz_q;
`endif
    case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        cnt_d    = '0;
        sr_d     = '0;
`ifdef DIV_ZERO_FLAG_EN
        dz_d     = 1'b0;
`endif
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d   = S_ON;
            div_mag_d = mag2;
            signed_d  = signed_div_i;
            sign1_d   = opdata1_i[DATA_W-1];
            sign2_d   = opdata2_i[DATA_W-1];
            sr_d      = {{(DATA_W+1){1'b0}}, mag1};
          end
        end
      end
      S_BYZERO: begin
        state_d  = S_END;
        ready_d  = 1'b1;
        result_d = '0;
`ifdef DIV_ZERO_FLAG_EN
        dz_d     = 1'b1;
`endif
      end
      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
          sr_d     = '0;
          cnt_d    = '0;
        end else begin
          sr_d  = iter_sr;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W-1)) begin
            state_d  = S_END;
            ready_d  = 1'b1;
            result_d = {rem_fin, quo_fin};
          end
        end
      end
      S_END: begin
        if (!start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
`ifdef DIV_ZERO_FLAG_EN
          dz_d     = 1'b0;
`endif
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      sr_q      <= '0;
      div_mag_q <= '0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      div_mag_q <= div_mag_d;
      signed_q  <= signed_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
      dz_q      <= dz_d;
`endif
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero_o = dz_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, annul, handshake, reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero_o;
`endif

  int n_pass  = 0;
  int n_total = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero_o   (div_zero_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives a request, returns after the acceptance edge plus however many edges it
  // took for ready_o to show (bounded at 100).
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
    lat = 0;
    while (!ready_o && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic drop_start(input string tag);
    start_i = 1'b0;
    tick();
    chk({tag, "_drop_rdy"}, {63'b0, ready_o}, 64'd0);
    chk({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  int lat;

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    tick(); tick();
    chk("rst_rdy", {63'b0, ready_o}, 64'd0);
    chk("rst_res", result_o, 64'd0);
    rst = 1'b0;
    tick();

    // divu 100/7: ready after edge N+32 (cycle N+33), hold 5 cycles, then drop
    run_div(1'b0, 32'd100, 32'd7, lat);
    chk("u100_7_lat", 64'(lat), 64'd32);
    chk("u100_7_res", result_o, {32'h2, 32'hE});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_rdy", {63'b0, ready_o}, 64'd1);
      chk("hold_res", result_o, {32'h2, 32'hE});
    end
    drop_start("u100_7");

    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    chk("s_m7_2_lat", 64'(lat), 64'd32);
    chk("s_m7_2_res", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    drop_start("s_m7_2");

    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    chk("s_7_m2_res", result_o, {32'h1, 32'hFFFF_FFFD});
    drop_start("s_7_m2");

    // divide by zero
    run_div(1'b0, 32'd5, 32'd0, lat);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_res", result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk("dz_flag", {63'b0, div_zero_o}, 64'd1);
`endif
    drop_start("dz");
`ifdef DIV_ZERO_FLAG_EN
    chk("dz_flag_clr", {63'b0, div_zero_o}, 64'd0);
`endif

    // annul after 10 iterations, then a fresh 9/3 accepted on the very next edge
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    tick();
    repeat (10) tick();
    chk("ann_pre_rdy", {63'b0, ready_o}, 64'd0);
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    chk("ann_rdy", {63'b0, ready_o}, 64'd0);
    chk("ann_res", result_o, 64'd0);
    run_div(1'b0, 32'd9, 32'd3, lat);
    chk("ann_9_3_lat", 64'(lat), 64'd32);
    chk("ann_9_3_res", result_o, {32'h0, 32'h3});
    drop_start("ann_9_3");

    // reset in the middle of iteration 20
    signed_div_i = 1'b0; opdata1_i = 32'h0000_FFFF; opdata2_i = 32'd3; start_i = 1'b1;
    tick();
    repeat (19) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_rdy", {63'b0, ready_o}, 64'd0);
    chk("mid_rst_res", result_o, 64'd0);
    rst = 1'b0; start_i = 1'b0;
    tick();
    chk("post_rst_rdy", {63'b0, ready_o}, 64'd0);

    // edge values; 3/10 right after reset also shows the unit came back in FREE
    run_div(1'b0, 32'd3, 32'd10, lat);
    chk("u3_10_lat", 64'(lat), 64'd32);
    chk("u3_10_res", result_o, {32'h3, 32'h0});
    drop_start("u3_10");

    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("s_min_m1_res", result_o, {32'h0, 32'h8000_0000});
    drop_start("s_min_m1");

    run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("u_max_max_res", result_o, {32'h0, 32'h1});
    drop_start("u_max_max");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle 32-bit integer divider for the EX stage. It is the producer of HI/LO write data for div/divu: the 64-bit result {remainder, quotient} travels down the pipeline and is written into HI (remainder) and LO (quotient) at WB. It uses a restoring shift-subtract algorithm, one quotient bit per cycle. The EX-stage controller holds start_i high and stalls the pipeline until ready_o is asserted.

Parameters:
DATA_W, 32, operand width; the result is 2*DATA_W bits.
CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
signed_div_i  input  1  1 = signed div, 0 = divu; sampled at start acceptance
opdata1_i  input  DATA_W  dividend; sampled at start acceptance
opdata2_i  input  DATA_W  divisor; sampled at start acceptance
start_i  input  1  request; held high by EX until it has consumed ready_o
annul_i  input  1  abort the current division (branch-delay flush or exception)
result_o  output  2*DATA_W  {remainder[63:32] -> HI, quotient[31:0] -> LO}
ready_o  output  1  result_o is valid

Behaviour:
- The reset value of every output and state register is 0: state FREE, ready_o=0, result_o=0, counter=0.
- Reset has priority over all other inputs. Reset during any state returns the unit to FREE on that edge.
- All outputs are registered. No combinational path runs from any input to any output.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, divisor=0 -> BYZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON.
  - On entry to ON, latch the operand magnitudes: two's-complement negate opdata1_i if signed_div_i=1 and bit 31=1; same rule for opdata2_i.
  - Latch signed_div_i and the sign bits of both operands.
  - Clear the counter and the 65-bit partial-remainder/dividend shift register.
  - Otherwise stay in FREE, with ready_o=0 and result_o=0.
- BYZERO: next state is END unconditionally, with result_o=0.
- ON:
  - If annul_i=1 -> FREE on this edge. Clear ready_o and result_o; discard the partial result.
  - Else perform one iteration: shift left; trial-subtract the divisor magnitude from the upper bits.
  - If the subtraction does not borrow, keep the difference and shift in quotient bit 1. Otherwise keep the shifted value and shift in 0.
  - Increment the counter.
  - The iteration in which the counter reaches DATA_W also transitions to END.
- Entry to END from ON:
  - quotient = magnitude quotient, negated if signed_div and the operand signs differ.
  - remainder = magnitude remainder, negated if signed_div and the dividend sign is 1 (the remainder takes the sign of the dividend).
  - Set ready_o=1 and load result_o={remainder, quotient}.
- END:
  - result_o and ready_o hold while start_i=1.
  - When start_i=0 -> FREE. ready_o=0 and result_o=0 on the following cycle.
  - annul_i is ignored in END.
- Latency:
  - Start sampled in FREE at edge N.
  - Normal division: the ON iterations occupy the next DATA_W cycles, and ready_o=1 during cycle N+DATA_W+1 (N+33 at default width).
  - Divide by zero: ready_o=1 during cycle N+2.
- Boundary cases:
  - 0x80000000 / 0xFFFFFFFF signed yields quotient 0x80000000, remainder 0. There is no trap.
  - Dividend magnitude < divisor magnitude yields quotient 0 and remainder = dividend.
  - A start_i pulse while in ON or BYZERO is ignored; operands are latched only at acceptance.

Optional Feature:
DIV_ZERO_FLAG_EN
- Defined: adds output port div_zero_o (1 bit, registered, reset 0).
  - It is set to 1 on entry to END from BYZERO, together with ready_o.
  - It is cleared wherever ready_o is cleared.
  - result_o is still 0.
- Undefined: the port is absent. Divide by zero is silent, giving result_o=0 with normal ready_o timing.

Test Plan:
- Unsigned: divu, 100 / 7, start held high -> ready_o=1 exactly 33 cycles after acceptance, result_o = {0x00000002, 0x0000000E}.
- Signed: div, 0xFFFFFFF9 (-7) / 2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Repeat with 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
- Divide by zero: 5 / 0 -> ready_o=1 two cycles after acceptance, result_o=0. With DIV_ZERO_FLAG_EN, div_zero_o=1 in the same cycle.
- Annul: pulse annul_i at iteration 10 -> FREE next cycle and ready_o never rises. A new divu 9 / 3 is then accepted -> {0, 3} after 33 cycles.
- Handshake and reset: hold start_i for 5 cycles in END -> ready_o and result_o stable; drop start_i -> ready_o=0 the next cycle. Assert rst at iteration 20 -> all outputs 0 on the next cycle and the state is FREE.
- Edge values: signed 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}. Unsigned 0xFFFFFFFF / 0xFFFFFFFF -> {0, 1}. Unsigned 3 / 10 -> {3, 0}.
